// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every request, response and memory-port signal handled by
//   mem_port_arbiter. Clock and reset stay plain module ports.
//
//   Modports
//     slave  : the arbiter's view. It takes requests from the fetch and
//              memory stages and drives the shared memory port.
//     master : the surrounding system's view (pipeline stages plus memory).
//
//   Parameter
//     N : address/data width. It must match the N of mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int N = 32
);
    // fetch requester
    logic         i_req;
    logic [N-1:0] i_addr;
    logic         flush;
    logic [N-1:0] i_rdata;
    logic         i_done;
    logic         i_stall;

    // data requester
    logic         d_req;
    logic         d_wr;
    logic [N-1:0] d_addr;
    logic [N-1:0] d_wdata;
    logic [N-1:0] d_rdata;
    logic         d_done;
    logic         d_stall;

    // halt / dump gating
    logic         halt;
    logic         halted;

    // shared memory port
    logic         mem_en;
    logic         mem_wr_en;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_valid;
    logic [N-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, flush,
        input  d_req, d_wr, d_addr, d_wdata,
        input  halt,
        input  mem_valid, mem_rdata,
        output i_rdata, i_done, i_stall,
        output d_rdata, d_done, d_stall,
        output halted,
        output mem_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, flush,
        output d_req, d_wr, d_addr, d_wdata,
        output halt,
        output mem_valid, mem_rdata,
        input  i_rdata, i_done, i_stall,
        input  d_rdata, d_done, d_stall,
        input  halted,
        input  mem_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the fetch stage (instruction reads) and
//   the memory stage (data reads/writes). Only one access is in flight at
//   a time. Each access follows this sequence:
//     IDLE --grant--> WAIT_x (mem_en pulses in the first cycle)
//          --mem_valid--> RESP_x (done pulses) --> IDLE
//   Read data is registered toward the winning requester. A requester that
//   is still waiting sees stall. halt blocks new grants, and halted reports
//   that the port is idle so a memory dump can proceed safely.
//
//   Ports
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : mem_port_arbiter_if.slave carrying these signals:
//              i_req/i_addr/flush        fetch request and redirect
//              d_req/d_wr/d_addr/d_wdata data request
//              halt/halted               grant gating and idle indication
//              mem_en/mem_wr_en/mem_addr/mem_wdata/mem_valid/mem_rdata
//              i_rdata/i_done/i_stall, d_rdata/d_done/d_stall
//
//   Build option
//     ARB_ROUND_ROBIN_EN : when defined, simultaneous requests alternate
//                          between the two requesters using a last_grant
//                          register. When undefined, data always wins.
module mem_port_arbiter #(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT_D = 3'd1;
    localparam logic [2:0] ST_WAIT_I = 3'd2;
    localparam logic [2:0] ST_RESP_D = 3'd3;
    localparam logic [2:0] ST_RESP_I = 3'd4;

    logic [2:0]   state_reg,     state_next;
    logic         drop_reg,      drop_next;
    logic         mem_en_reg,    mem_en_next;
    logic         mem_wr_en_reg, mem_wr_en_next;
    logic [N-1:0] mem_addr_reg,  mem_addr_next;
    logic [N-1:0] mem_wdata_reg, mem_wdata_next;
    logic [N-1:0] i_rdata_reg,   i_rdata_next;
    logic [N-1:0] d_rdata_reg,   d_rdata_next;
    logic         i_done_reg,    i_done_next;
    logic         d_done_reg,    d_done_next;
    // Set at the first clock edge after reset. It keeps halted low while
    // reset is asserted and until the FSM has actually been clocked.
    logic         started_reg;

    logic         i_eligible;
    logic         grant_d;
    logic         grant_i;

    // A redirected fetch is not worth starting.
    assign i_eligible = bus.i_req & ~bus.flush;

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant: 0 = instruction, 1 = data. On a tie, the requester that
    // did not win last time gets the port.
    logic last_grant_reg, last_grant_next;

    assign grant_d = bus.d_req & (~i_eligible | ~last_grant_reg);
`else
    assign grant_d = bus.d_req;
`endif
    assign grant_i = i_eligible & ~grant_d;

    always_comb begin
        state_next     = state_reg;
        drop_next      = drop_reg;
        mem_en_next    = 1'b0;
        mem_wr_en_next = mem_wr_en_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        i_rdata_next   = i_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        i_done_next    = 1'b0;
        d_done_next    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_next = last_grant_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (!bus.halt) begin
                    if (grant_d) begin
                        mem_en_next    = 1'b1;
                        mem_wr_en_next = bus.d_wr;
                        mem_addr_next  = bus.d_addr;
                        mem_wdata_next = bus.d_wdata;
                        drop_next      = 1'b0;
                        state_next     = ST_WAIT_D;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_next = 1'b1;
`endif
                    end else if (grant_i) begin
                        // mem_wdata keeps its old value; reads ignore it.
                        mem_en_next    = 1'b1;
                        mem_wr_en_next = 1'b0;
                        mem_addr_next  = bus.i_addr;
                        drop_next      = 1'b0;
                        state_next     = ST_WAIT_I;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_next = 1'b0;
`endif
                    end
                end
            end

            ST_WAIT_D: begin
                if (bus.mem_valid) begin
                    // Writes return no data. Keep the last read value.
                    if (!mem_wr_en_reg) begin
                        d_rdata_next = bus.mem_rdata;
                    end
                    d_done_next = 1'b1;
                    state_next  = ST_RESP_D;
                end
            end

            ST_WAIT_I: begin
                if (bus.mem_valid) begin
                    // A fetch redirected at any point during the access is
                    // drained silently. The memory must still finish it
                    // before the port can be reused.
                    if (drop_reg || bus.flush) begin
                        state_next = ST_IDLE;
                    end else begin
                        i_rdata_next = bus.mem_rdata;
                        i_done_next  = 1'b1;
                        state_next   = ST_RESP_I;
                    end
                    drop_next = 1'b0;
                end else if (bus.flush) begin
                    drop_next = 1'b1;
                end
            end

            ST_RESP_D: state_next = ST_IDLE;
            ST_RESP_I: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            drop_reg      <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_wr_en_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            i_done_reg    <= 1'b0;
            d_done_reg    <= 1'b0;
            started_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drop_reg      <= drop_next;
            mem_en_reg    <= mem_en_next;
            mem_wr_en_reg <= mem_wr_en_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            i_rdata_reg   <= i_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            i_done_reg    <= i_done_next;
            d_done_reg    <= d_done_next;
            started_reg   <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`endif

    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_wr_en = mem_wr_en_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.i_rdata   = i_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.i_done    = i_done_reg;
    assign bus.d_done    = d_done_reg;
    assign bus.i_stall   = bus.i_req & ~i_done_reg;
    assign bus.d_stall   = bus.d_req & ~d_done_reg;
    assign bus.halted    = bus.halt & (state_reg == ST_IDLE) & started_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. The checks run in this order:
//     - reset values
//     - a table of single grant decisions
//     - hand-timed sequences: fetch only, a tie, flush, halt, and reset in
//       the middle of an access
//     - round-robin alternation, only when ARB_ROUND_ROBIN_EN is defined
//     - a randomized run checked against a transaction-level model
module tb_mem_port_arbiter;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N(N)) bus();

    mem_port_arbiter #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.flush     = 1'b0;
        bus.d_req     = 1'b0;
        bus.d_wr      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.halt      = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // One grant decision, taken from IDLE. exp_who: 0 none, 1 fetch, 2 data.
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        flush;
        logic        d_req;
        logic        d_wr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        halt;
        int          exp_who;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[9];

    // Global time bound: the bench must never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // randomized-run state
    logic [31:0] mem_arr[16];
    logic [31:0] ref_mem[16];
    logic        i_p, d_p, d_w, prev_i, prev_d, last_was_d;
    int          i_idx, d_idx, busy, who, resp_cnt, valid_cyc, idx;
    int          i_age, d_age, max_age, txns;
    logic [31:0] d_wd;

    initial begin
        // d read, fetch, tie, fetch flushed, halt blocks both, nothing, tie
        // with the fetch flushed, and a plain write.
        vecs[0] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h40,  32'h0,    1'b0, 2, 1'b0, 32'h40,  32'h0,    1'b0};
        vecs[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1, 1'b0, 32'h100, 32'h0,    1'b0};
        vecs[2] = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h200, 32'h55,   1'b0, 2, 1'b1, 32'h200, 32'h55,   1'b0};
        vecs[3] = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 0, 1'b0, 32'h0,   32'h0,    1'b0};
        vecs[4] = '{1'b1, 32'h10C, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 0, 1'b0, 32'h0,   32'h0,    1'b1};
        vecs[5] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h44,  32'h9,    1'b1, 0, 1'b0, 32'h0,   32'h0,    1'b1};
        vecs[6] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 0, 1'b0, 32'h0,   32'h0,    1'b0};
        vecs[7] = '{1'b1, 32'h110, 1'b1, 1'b1, 1'b0, 32'h44,  32'h0,    1'b0, 2, 1'b0, 32'h44,  32'h0,    1'b0};
        vecs[8] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h48,  32'hA5A5, 1'b0, 2, 1'b1, 32'h48,  32'hA5A5, 1'b0};

        // ---------------- reset values (halt high, halted must stay low)
        idle_inputs();
        bus.halt = 1'b1;
        #1;
        chk("rst_mem_en",    32'(bus.mem_en),    0);
        chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rst_mem_addr",  bus.mem_addr,       0);
        chk("rst_mem_wdata", bus.mem_wdata,      0);
        chk("rst_i_rdata",   bus.i_rdata,        0);
        chk("rst_d_rdata",   bus.d_rdata,        0);
        chk("rst_i_done",    32'(bus.i_done),    0);
        chk("rst_d_done",    32'(bus.d_done),    0);
        chk("rst_halted",    32'(bus.halted),    0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.halt = 1'b0;
        @(negedge clk);

        // ---------------- table of grant decisions
        for (int v = 0; v < 9; v++) begin
            bus.i_req   = vecs[v].i_req;
            bus.i_addr  = vecs[v].i_addr;
            bus.flush   = vecs[v].flush;
            bus.d_req   = vecs[v].d_req;
            bus.d_wr    = vecs[v].d_wr;
            bus.d_addr  = vecs[v].d_addr;
            bus.d_wdata = vecs[v].d_wdata;
            bus.halt    = vecs[v].halt;
            @(negedge clk);
            chk($sformatf("vec%0d_mem_en", v), 32'(bus.mem_en), 32'(vecs[v].exp_who != 0));
            chk($sformatf("vec%0d_halted", v), 32'(bus.halted), 32'(vecs[v].exp_halted));
            chk($sformatf("vec%0d_i_stall", v), 32'(bus.i_stall), 32'(vecs[v].i_req));
            chk($sformatf("vec%0d_d_stall", v), 32'(bus.d_stall), 32'(vecs[v].d_req));
            if (vecs[v].exp_who != 0) begin
                chk($sformatf("vec%0d_mem_addr", v), bus.mem_addr, vecs[v].exp_addr);
                chk($sformatf("vec%0d_mem_wr_en", v), 32'(bus.mem_wr_en), 32'(vecs[v].exp_wr));
                if (vecs[v].exp_wr) begin
                    chk($sformatf("vec%0d_mem_wdata", v), bus.mem_wdata, vecs[v].exp_wdata);
                end
                bus.mem_valid = 1'b1;
                bus.mem_rdata = 32'hA000_0000 + 32'(v);
                @(negedge clk);
                bus.mem_valid = 1'b0;
                chk($sformatf("vec%0d_i_done", v), 32'(bus.i_done), 32'(vecs[v].exp_who == 1));
                chk($sformatf("vec%0d_d_done", v), 32'(bus.d_done), 32'(vecs[v].exp_who == 2));
                if (vecs[v].exp_who == 1) begin
                    chk($sformatf("vec%0d_i_rdata", v), bus.i_rdata, 32'hA000_0000 + 32'(v));
                end else if (!vecs[v].exp_wr) begin
                    chk($sformatf("vec%0d_d_rdata", v), bus.d_rdata, 32'hA000_0000 + 32'(v));
                end
            end
            $display("vec %0d: who=%0d mem_addr=0x%08h mem_wr_en=%0b halted=%0b",
                     v, vecs[v].exp_who, bus.mem_addr, bus.mem_wr_en, bus.halted);
            idle_inputs();
            @(negedge clk);
        end

        // ---------------- fetch only, memory answers 2 cycles after mem_en
        bus.i_req = 1'b1;
        bus.i_addr = 32'h100;
        @(negedge clk);
        chk("fo_mem_en",    32'(bus.mem_en),    1);
        chk("fo_mem_addr",  bus.mem_addr,       32'h100);
        chk("fo_mem_wr_en", 32'(bus.mem_wr_en), 0);
        chk("fo_stall1",    32'(bus.i_stall),   1);
        @(negedge clk);
        chk("fo_en_once",   32'(bus.mem_en),    0);
        chk("fo_stall2",    32'(bus.i_stall),   1);
        chk("fo_no_done",   32'(bus.i_done),    0);
        @(negedge clk);
        chk("fo_stall3",    32'(bus.i_stall),   1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("fo_i_done",    32'(bus.i_done),    1);
        chk("fo_i_rdata",   bus.i_rdata,        32'hDEAD_BEEF);
        chk("fo_stall_end", 32'(bus.i_stall),   0);
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("fo_done_once", 32'(bus.i_done),    0);
        chk("fo_no_regrant", 32'(bus.mem_en),   0);
        $display("seq fetch_only: i_rdata=0x%08h", bus.i_rdata);

        // ---------------- simultaneous request, data wins
        bus.i_req = 1'b1;  bus.i_addr = 32'h104;
        bus.d_req = 1'b1;  bus.d_wr = 1'b1;  bus.d_addr = 32'h200;  bus.d_wdata = 32'h55;
        @(negedge clk);
        chk("sim_d_en",    32'(bus.mem_en),    1);
        chk("sim_d_wr",    32'(bus.mem_wr_en), 1);
        chk("sim_d_addr",  bus.mem_addr,       32'h200);
        chk("sim_d_wdata", bus.mem_wdata,      32'h55);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h0;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("sim_d_done",  32'(bus.d_done),    1);
        chk("sim_no_en",   32'(bus.mem_en),    0);
        bus.d_req = 1'b0;  bus.d_wr = 1'b0;
        @(negedge clk);
        chk("sim_idle_en", 32'(bus.mem_en),    0);
        chk("sim_i_stall", 32'(bus.i_stall),   1);
        @(negedge clk);
        chk("sim_i_en",    32'(bus.mem_en),    1);
        chk("sim_i_addr",  bus.mem_addr,       32'h104);
        chk("sim_i_wr",    32'(bus.mem_wr_en), 0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h1234;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("sim_i_done",  32'(bus.i_done),    1);
        chk("sim_i_rdata", bus.i_rdata,        32'h1234);
        bus.i_req = 1'b0;
        @(negedge clk);
        $display("seq simultaneous: data then fetch");

        // ---------------- flush while the fetch is outstanding
        bus.i_req = 1'b1;  bus.i_addr = 32'h180;
        @(negedge clk);
        chk("fl_en",       32'(bus.mem_en),    1);
        chk("fl_addr",     bus.mem_addr,       32'h180);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.i_req = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("fl_no_done1", 32'(bus.i_done),    0);
        @(negedge clk);
        chk("fl_no_done2", 32'(bus.i_done),    0);
        chk("fl_rdata",    bus.i_rdata,        32'h1234);
        chk("fl_no_en",    32'(bus.mem_en),    0);
        bus.i_req = 1'b1;  bus.i_addr = 32'h300;
        @(negedge clk);
        chk("fl_next_en",   32'(bus.mem_en),   1);
        chk("fl_next_addr", bus.mem_addr,      32'h300);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h3333;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("fl_next_done",  32'(bus.i_done),  1);
        chk("fl_next_rdata", bus.i_rdata,      32'h3333);
        bus.i_req = 1'b0;
        @(negedge clk);
        $display("seq flush: dropped fetch, then 0x300 returned 0x%08h", bus.i_rdata);

        // ---------------- halt raised during WAIT_D
        bus.d_req = 1'b1;  bus.d_wr = 1'b0;  bus.d_addr = 32'h40;
        @(negedge clk);
        chk("ht_en", 32'(bus.mem_en), 1);
        bus.halt = 1'b1;
        @(negedge clk);
        chk("ht_halted_wait", 32'(bus.halted), 0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("ht_d_done",      32'(bus.d_done), 1);
        chk("ht_d_rdata",     bus.d_rdata,     32'hCAFE_F00D);
        chk("ht_halted_resp", 32'(bus.halted), 0);
        bus.d_req = 1'b0;
        bus.i_req = 1'b1;  bus.i_addr = 32'h500;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ht_halted_%0d", k), 32'(bus.halted), 1);
            chk($sformatf("ht_no_en_%0d", k),  32'(bus.mem_en), 0);
            @(negedge clk);
        end
        bus.halt = 1'b0;
        @(negedge clk);
        chk("ht_resume_en",   32'(bus.mem_en), 1);
        chk("ht_resume_addr", bus.mem_addr,    32'h500);
        chk("ht_unhalted",    32'(bus.halted), 0);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h5555;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("ht_resume_done", 32'(bus.i_done), 1);
        bus.i_req = 1'b0;
        @(negedge clk);
        $display("seq halt: d_rdata=0x%08h", bus.d_rdata);

        // ---------------- reset in the middle of a fetch, then a stray mem_valid
        bus.i_req = 1'b1;  bus.i_addr = 32'h600;
        @(negedge clk);
        chk("rm_en", 32'(bus.mem_en), 1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.halt = 1'b1;
        #1;
        chk("rm_mem_en",    32'(bus.mem_en),    0);
        chk("rm_mem_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rm_mem_addr",  bus.mem_addr,       0);
        chk("rm_mem_wdata", bus.mem_wdata,      0);
        chk("rm_i_rdata",   bus.i_rdata,        0);
        chk("rm_d_rdata",   bus.d_rdata,        0);
        chk("rm_i_done",    32'(bus.i_done),    0);
        chk("rm_d_done",    32'(bus.d_done),    0);
        chk("rm_halted",    32'(bus.halted),    0);
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("rm_halted_hold", 32'(bus.halted), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rm_halted_after", 32'(bus.halted), 1);
        bus.halt = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h6666;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("rm_stray_i_done", 32'(bus.i_done), 0);
        chk("rm_stray_d_done", 32'(bus.d_done), 0);
        chk("rm_stray_rdata",  bus.i_rdata,     0);
        @(negedge clk);
        chk("rm_idle_i_done",  32'(bus.i_done), 0);
        chk("rm_idle_en",      32'(bus.mem_en), 0);
        $display("seq reset_mid_access: port idle after stray mem_valid");

`ifdef ARB_ROUND_ROBIN_EN
        // ---------------- round robin with both requesters always asking
        begin
            int grants;
            logic [3:0] order;
            grants = 0;
            order = '0;
            bus.i_req = 1'b1;  bus.i_addr = 32'h700;
            bus.d_req = 1'b1;  bus.d_wr = 1'b1;  bus.d_addr = 32'h800;  bus.d_wdata = 32'h77;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                bus.mem_valid = 1'b0;
                if (bus.mem_en && grants < 4) begin
                    order[grants] = bus.mem_wr_en;
                    grants++;
                    bus.mem_valid = 1'b1;
                end else if ((bus.i_done || bus.d_done) && grants >= 4) begin
                    bus.i_req = 1'b0;
                    bus.d_req = 1'b0;
                    break;
                end
            end
            chk("rr_grants", 32'(grants), 4);
            chk("rr_order",  32'(order),  32'b0101);
            $display("seq round_robin: order(bit=data)=%b", order);
            idle_inputs();
            @(negedge clk);
        end
`endif

        // ---------------- randomized run against a transaction-level model
        for (int k = 0; k < 16; k++) begin
            mem_arr[k] = 32'h1000_0000 + 32'(k) * 32'h11;
            ref_mem[k] = 32'h1000_0000 + 32'(k) * 32'h11;
        end
        i_p = 1'b0;  d_p = 1'b0;  d_w = 1'b0;  prev_i = 1'b0;  prev_d = 1'b0;
        // The last grant before this point went to the fetch side.
        last_was_d = 1'b0;
        i_idx = 0;  d_idx = 0;  busy = 0;  resp_cnt = -1;  valid_cyc = -10;
        i_age = 0;  d_age = 0;  max_age = 0;  txns = 0;  d_wd = '0;
        idle_inputs();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_i_stall", 32'(bus.i_stall), 32'(i_p & ~bus.i_done));
            chk("rnd_d_stall", 32'(bus.d_stall), 32'(d_p & ~bus.d_done));

            if (bus.mem_en) begin
                // Pick the winner from the requests that were present at the
                // grant edge.
                who = 0;
                if (prev_d && prev_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    who = last_was_d ? 1 : 2;
`else
                    who = 2;
`endif
                end else if (prev_d) begin
                    who = 2;
                end else if (prev_i) begin
                    who = 1;
                end
                chk("rnd_grant_port_free", 32'(busy), 0);
                chk("rnd_grant_has_req", 32'(who != 0), 1);
                if (who == 2) begin
                    chk("rnd_d_addr", bus.mem_addr, 32'(d_idx) * 4);
                    chk("rnd_d_wr",   32'(bus.mem_wr_en), 32'(d_w));
                    if (d_w) chk("rnd_d_wdata", bus.mem_wdata, d_wd);
                end else if (who == 1) begin
                    chk("rnd_i_addr", bus.mem_addr, 32'(i_idx) * 4);
                    chk("rnd_i_wr",   32'(bus.mem_wr_en), 0);
                end
                busy = who;
                last_was_d = (who == 2);
                resp_cnt = int'($urandom_range(0, 3));
            end

            if (bus.i_done) begin
                chk("rnd_i_owner",   32'(busy), 1);
                chk("rnd_i_latency", 32'(c), 32'(valid_cyc + 1));
                chk("rnd_i_rdata",   bus.i_rdata, ref_mem[i_idx]);
                $display("rnd txn %0d: fetch addr=0x%08h data=0x%08h", txns, i_idx * 4, bus.i_rdata);
                busy = 0;
                i_p = 1'b0;
                txns++;
            end
            if (bus.d_done) begin
                chk("rnd_d_owner",   32'(busy), 2);
                chk("rnd_d_latency", 32'(c), 32'(valid_cyc + 1));
                if (d_w) begin
                    ref_mem[d_idx] = d_wd;
                end else begin
                    chk("rnd_d_rdata", bus.d_rdata, ref_mem[d_idx]);
                end
                $display("rnd txn %0d: data %s addr=0x%08h data=0x%08h", txns, d_w ? "wr" : "rd",
                         d_idx * 4, d_w ? d_wd : bus.d_rdata);
                busy = 0;
                d_p = 1'b0;
                txns++;
            end

            // Memory model: answer once per mem_en after 0..3 extra cycles.
            bus.mem_valid = 1'b0;
            bus.mem_rdata = $urandom;
            if (resp_cnt == 0) begin
                idx = int'(bus.mem_addr[5:2]);
                bus.mem_valid = 1'b1;
                bus.mem_rdata = mem_arr[idx];
                if (bus.mem_wr_en) mem_arr[idx] = bus.mem_wdata;
                valid_cyc = c;
                resp_cnt = -1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end

            // New requests; the last 100 cycles let everything drain.
            if (c < 2900) begin
                if (!i_p && $urandom_range(0, 2) == 0) begin
                    i_p = 1'b1;
                    i_idx = int'($urandom_range(0, 15));
                    i_age = 0;
                end
                if (!d_p && !bus.d_done && $urandom_range(0, 3) == 0) begin
                    d_p = 1'b1;
                    d_idx = int'($urandom_range(0, 15));
                    d_w = 1'($urandom_range(0, 1));
                    d_wd = $urandom;
                    d_age = 0;
                end
            end
            bus.i_req   = i_p;
            bus.i_addr  = i_p ? 32'(i_idx) * 4 : $urandom;
            bus.d_req   = d_p;
            bus.d_wr    = d_p ? d_w : 1'b0;
            bus.d_addr  = d_p ? 32'(d_idx) * 4 : $urandom;
            bus.d_wdata = d_p ? d_wd : $urandom;
            if (i_p) i_age++;
            if (d_p) d_age++;
            if (i_age > max_age) max_age = i_age;
            if (d_age > max_age) max_age = d_age;
            prev_i = i_p;
            prev_d = d_p;
        end
        chk("rnd_drained",  32'(i_p | d_p), 0);
        chk("rnd_port_idle", 32'(busy), 0);
        chk("rnd_max_wait_ok", 32'(max_age < 150), 1);
        chk("rnd_enough_txns", 32'(txns > 100), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
